bram_be_requester: RTL and testbench
====================================

Name: bram_be_requester

Overview:
Initiator-side front end for a single-port byte-enabled block RAM. It accepts byte, half-word and word load/store requests on a valid/ready channel and drives the RAM port (DI/ADDR/WE/RE/BE). It tracks the RAM's one-cycle read latency, extracts and extends load data, and returns load results on a back-pressurable valid/ready response channel. It sits between a core's load/store unit and the scratchpad BRAM.

Parameters:
ADDR_WIDTH, 10, RAM word-address width
DATA_WIDTH, 32, RAM word width; must be 32 (BE_WIDTH = 4)
BE_WIDTH, DATA_WIDTH/8, byte lanes per word (derived, not overridden)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when valid && ready (fire)
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH+2  byte address
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_signed  in  1  sign-extend load result
req_data  in  DATA_WIDTH  store data, right-aligned
rsp_valid  out  1  load response present
rsp_ready  in  1  response consumed when valid && ready
rsp_data  out  DATA_WIDTH  extended load data
rsp_err  out  1  response belongs to a misaligned or illegal load
store_err  out  1  one-cycle pulse: misaligned or illegal store dropped
ram_di  out  DATA_WIDTH  RAM data in
ram_addr  out  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_be  out  BE_WIDTH  RAM byte enables
ram_do  in  DATA_WIDTH  RAM data out, valid the cycle after ram_re

Behaviour:
- Issue is combinational from the request on fire; at most one RAM op per cycle, so WE and RE are never both asserted.
- Misaligned: size 1 with addr[0] = 1; size 2 with addr[1:0] != 0; size 3 always misaligned.
- Store fire, aligned: ram_we = 1; ram_be = 0001/0011/1111 shifted left by addr[1:0]; ram_di = req_data replicated per size (byte x4, half x2).
- Store fire, misaligned: no RAM write; store_err = 1 next cycle.
- Load fire, aligned: ram_re = 1; ram_be = 0. Register {offset, size, signed, err = 0} in a 1-deep in-flight stage.
- Load fire, misaligned: no RAM read; in-flight stage gets err = 1; its response has rsp_data = 0 and rsp_err = 1.
- Cycle after a load issues: the lane selected by the offset is shifted down; sign- or zero-extended per req_signed; pushed into a 2-entry response FIFO.
- Load-to-response latency is 1 cycle when the FIFO is empty. rsp_* come from the FIFO head.
- Credit rule: loads_outstanding = fifo_count + inflight.
  - Loads are ready when loads_outstanding < 2.
  - Stores are ready whenever RESET is low.
  - req_ready is a function of req_write.
- Simultaneous FIFO push and pop with the FIFO full cannot occur, because of the credit rule.
- Responses are returned in load-issue order.
- Reset: req_ready, rsp_valid, rsp_err, store_err and all ram_* outputs = 0; FIFO empty; in-flight stage cleared. Read data returning in the cycle after reset is discarded.

Optional Feature:
STORE_ACK_EN
- Defined: every store, including misaligned ones, pushes a response with rsp_data = 0 and rsp_err = its misalignment flag. Stores then obey the same credit rule as loads. store_err is still pulsed.
- Undefined: stores produce no response, as described above.

Decomposition:
- Package bram_be_requester_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL)
  - in-flight struct {offset[1:0], size, signed, err, is_store}
  - response struct {data, err}
  - functions be_mask(size, offset) and extend(word, offset, size, signed)
- Sub-module resp_fifo2: 2-entry FIFO of the response struct with count output.

Test Plan:
- Store word 0xDEADBEEF at byte addr 0x10 -> ram_we = 1, ram_addr = 4, ram_be = 1111, ram_di = 0xDEADBEEF; no response.
- Store byte 0x80 at addr 0x13, then signed byte load at 0x13 -> ram_be = 1000 on the store; response 0xFFFFFF80, err = 0. Same load unsigned -> 0x00000080.
- Half load at 0x12 after the word store above, unsigned -> rsp_data = 0x0000DEAD, returned exactly 1 cycle after fire when rsp_ready = 1.
- Half load at 0x11 -> no ram_re; rsp_data = 0, rsp_err = 1. Word store at 0x02 -> no ram_we; store_err pulse.
- Hold rsp_ready = 0 and issue 3 back-to-back loads -> first two accepted, req_ready = 0 for the third. Release -> responses arrive in order, third then accepted.
- Assert RESET with one load in flight and one buffered -> next cycle rsp_valid = 0, req_ready = 1 after RESET falls; no stale response appears.

Source files
------------

// File: rtl/bram_be_requester_pkg.sv
// Shared types and byte-lane helpers for the byte-enabled BRAM requester.
// Lane arithmetic assumes a 32-bit RAM word with four byte lanes.
package bram_be_requester_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = WORD_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef struct packed {
    logic [1:0] offset;
    size_e      size;
    logic       sgn;
    logic       err;
    logic       is_store;
  } inflight_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              err;
  } rsp_t;

  function automatic logic misaligned(size_e size, logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      SZ_WORD: return (offset != 2'd0);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [LANES-1:0] be_mask(size_e size, logic [1:0] offset);
    logic [LANES-1:0] base;
    case (size)
      SZ_BYTE: base = 4'b0001;
      SZ_HALF: base = 4'b0011;
      SZ_WORD: base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << offset;
  endfunction

  // Right-aligned store data is copied into every lane so the byte enables alone pick the target.
  function automatic logic [WORD_W-1:0] replicate(size_e size, logic [WORD_W-1:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] extend(logic [WORD_W-1:0] word, logic [1:0] offset,
                                               size_e size, logic sgn);
    logic [WORD_W-1:0] lane;
    lane = word >> {offset, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: return {{16{sgn & lane[15]}}, lane[15:0]};
      SZ_WORD: return lane;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/bram_be_requester_if.sv
// Request, response and RAM-port signals of the BRAM requester.
// slave is the requester's view; master is the core/RAM side driving requests and ram_do.
interface bram_be_requester_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [DATA_WIDTH-1:0] req_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  store_err;

  logic [DATA_WIDTH-1:0] ram_di;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic                  ram_re;
  logic [BE_WIDTH-1:0]   ram_be;
  logic [DATA_WIDTH-1:0] ram_do;

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_signed, req_data,
    input  rsp_ready, ram_do,
    output req_ready, rsp_valid, rsp_data, rsp_err, store_err,
    output ram_di, ram_addr, ram_we, ram_re, ram_be
  );

  modport master (
    output req_valid, req_write, req_addr, req_size, req_signed, req_data,
    output rsp_ready, ram_do,
    input  req_ready, rsp_valid, rsp_data, rsp_err, store_err,
    input  ram_di, ram_addr, ram_we, ram_re, ram_be
  );

endinterface

// File: rtl/bram_be_requester_resp_fifo2.sv
// Two-entry response FIFO that falls through when empty, so a push shows on o_vld the same cycle.
// Pushing while full is unguarded: the requester's credit accounting never lets it happen.
module resp_fifo2
  import bram_be_requester_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_push,
  input  rsp_t       i_dat,
  input  logic       i_rdy,
  output logic       o_vld,
  output rsp_t       o_dat,
  output logic [1:0] o_count
);

  rsp_t       r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  logic w_empty;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  assign w_empty = (r_count == 2'd0);
  assign o_vld   = !w_empty || i_push;
  assign o_dat   = w_empty ? i_dat : r_mem[r_rd_ptr];
  assign w_pop   = o_vld && i_rdy;
  // An entry consumed straight off the bypass never touches storage.
  assign w_wr    = i_push && !(w_empty && i_rdy);
  assign w_rd    = w_pop && !w_empty;
  assign o_count = r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_rd) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

endmodule

// File: rtl/bram_be_requester.sv
// Byte-enabled BRAM requester: combinational RAM issue on fire, load response one cycle later via a 2-entry FIFO.
// req_ready drops once two responses are outstanding; STORE_ACK_EN makes stores return responses under the same credit.
module bram_be_requester
  import bram_be_requester_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  bram_be_requester_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  size_e                 w_size;
  logic [1:0]            w_offset;
  logic                  w_misal;
  logic [1:0]            w_fifo_count;
  logic [1:0]            w_outstanding;
  logic                  w_credit_ok;
  logic                  w_ready;
  logic                  w_fire;
  logic                  w_st_fire;
  logic                  w_ld_fire;
  logic                  w_track;
  logic                  w_we;
  logic                  w_re;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_di;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_push;
  rsp_t                  w_push_dat;
  logic                  w_rsp_rdy;
  logic                  w_fifo_vld;
  rsp_t                  w_head;
  logic                  w_rsp_vld;

  inflight_t r_inflight;
  logic      r_inflight_vld;
  logic      r_store_err;

  assign w_size   = size_e'(bus.req_size);
  assign w_offset = bus.req_addr[1:0];
  assign w_misal  = misaligned(w_size, w_offset);

  // The in-flight slot counts as outstanding, so the FIFO can never be pushed while full.
  assign w_outstanding = w_fifo_count + {1'b0, r_inflight_vld};
  assign w_credit_ok   = (w_outstanding < 2'd2);

`ifdef STORE_ACK_EN
  assign w_ready = !RESET && w_credit_ok;
  assign w_track = w_fire;
`else
  assign w_ready = !RESET && (bus.req_write || w_credit_ok);
  assign w_track = w_ld_fire;
`endif

  assign w_fire    = bus.req_valid && w_ready;
  assign w_st_fire = w_fire && bus.req_write;
  assign w_ld_fire = w_fire && !bus.req_write;

  assign w_we   = w_st_fire && !w_misal;
  assign w_re   = w_ld_fire && !w_misal;
  assign w_be   = w_we ? be_mask(w_size, w_offset) : '0;
  assign w_di   = w_we ? replicate(w_size, bus.req_data) : '0;
  assign w_addr = (w_we || w_re) ? bus.req_addr[ADDR_WIDTH+1:2] : '0;

  assign bus.req_ready = w_ready;
  assign bus.ram_we    = w_we;
  assign bus.ram_re    = w_re;
  assign bus.ram_be    = w_be;
  assign bus.ram_di    = w_di;
  assign bus.ram_addr  = w_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_inflight_vld <= 1'b0;
      r_inflight     <= '0;
      r_store_err    <= 1'b0;
    end else begin
      r_inflight_vld <= w_track;
      if (w_track) begin
        r_inflight <= '{offset:   w_offset,
                        size:     w_size,
                        sgn:      bus.req_signed,
                        err:      w_misal,
                        is_store: bus.req_write};
      end
      r_store_err <= w_st_fire && w_misal;
    end
  end

  // ram_do is only meaningful for an aligned load; errored and store entries return zero data.
  always_comb begin
    w_push_dat     = '0;
    w_push_dat.err = r_inflight.err;
    if (!r_inflight.err && !r_inflight.is_store) begin
      w_push_dat.data = extend(bus.ram_do, r_inflight.offset, r_inflight.size, r_inflight.sgn);
    end
  end

  assign w_push    = r_inflight_vld && !RESET;
  assign w_rsp_rdy = bus.rsp_ready && !RESET;

  resp_fifo2 u_resp_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_rdy   (w_rsp_rdy),
    .o_vld   (w_fifo_vld),
    .o_dat   (w_head),
    .o_count (w_fifo_count)
  );

  assign w_rsp_vld     = w_fifo_vld && !RESET;
  assign bus.rsp_valid = w_rsp_vld;
  assign bus.rsp_data  = w_rsp_vld ? w_head.data : '0;
  assign bus.rsp_err   = w_rsp_vld && w_head.err;
  assign bus.store_err = r_store_err && !RESET;

endmodule

// File: tb/tb_bram_be_requester.sv
// Directed bench for bram_be_requester with a byte-addressed reference memory and an in-order response scoreboard.
// A word-wide RAM model with one-cycle read latency sits on the RAM port.
module tb_bram_be_requester;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  bram_be_requester_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  bram_be_requester #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  exp_t q[$];
  exp_t m_exp;

  logic [31:0] ram [0:1023];
  logic [7:0]  bm  [0:4095];

  always @(posedge CLK) begin
    if (bus.ram_we) begin
      for (int j = 0; j < 4; j++) begin
        if (bus.ram_be[j]) ram[bus.ram_addr][8*j +: 8] <= bus.ram_di[8*j +: 8];
      end
    end
    if (bus.ram_re) bus.ram_do <= ram[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responses are compared in issue order whenever a handshake is about to complete.
  always @(negedge CLK) begin
    if (!RESET && bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_pending", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        m_exp = q.pop_front();
        chk("rsp_data", bus.rsp_data, m_exp.d);
        chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_exp.e});
      end
    end
  end

  function automatic logic mis_f(logic [11:0] a, logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic exp_t exp_load(logic [11:0] a, logic [1:0] sz, logic sg);
    exp_t        r;
    logic [31:0] v;
    int          n;
    r.d = 32'd0;
    r.e = 1'b1;
    if (mis_f(a, sz)) return r;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = bm[int'(a) + i];
    if (sg && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    r.d = v;
    r.e = 1'b0;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [1:0] sz, input logic sg,
                       input logic [31:0] d, input logic exp_rdy, input string tag);
    logic        mis;
    logic [3:0]  be;
    logic [31:0] di;
    int          n;
    exp_t        e;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_data   = d;
    mis = mis_f(a, sz);
    n   = 1 << sz;
    @(negedge CLK);
    chk({tag, "_ready"}, {31'd0, bus.req_ready}, {31'd0, exp_rdy});
    if (bus.req_ready) begin
      if (w) begin
        chk({tag, "_we"}, {31'd0, bus.ram_we}, {31'd0, !mis});
        chk({tag, "_re"}, {31'd0, bus.ram_re}, 32'd0);
        if (!mis) begin
          be = 4'(((1 << n) - 1) << a[1:0]);
          for (int j = 0; j < 4; j++) di[8*j +: 8] = d[8*(j % n) +: 8];
          chk({tag, "_be"}, {28'd0, bus.ram_be}, {28'd0, be});
          chk({tag, "_di"}, bus.ram_di, di);
          chk({tag, "_addr"}, {22'd0, bus.ram_addr}, {22'd0, a[11:2]});
          for (int i = 0; i < n; i++) bm[int'(a) + i] = d[8*i +: 8];
        end
`ifdef STORE_ACK_EN
        e.d = 32'd0;
        e.e = mis;
        q.push_back(e);
`endif
      end else begin
        chk({tag, "_re"}, {31'd0, bus.ram_re}, {31'd0, !mis});
        chk({tag, "_we"}, {31'd0, bus.ram_we}, 32'd0);
        chk({tag, "_be"}, {28'd0, bus.ram_be}, 32'd0);
        if (!mis) chk({tag, "_addr"}, {22'd0, bus.ram_addr}, {22'd0, a[11:2]});
        e = exp_load(a, sz, sg);
        q.push_back(e);
      end
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    for (int i = 0; i < 4096; i++) bm[i] = 8'd0;
    RESET          = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 12'h010;
    bus.req_size   = 2'd2;
    bus.req_signed = 1'b0;
    bus.req_data   = 32'd0;
    bus.rsp_ready  = 1'b1;

    @(negedge CLK);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    chk("rst_store_err", {31'd0, bus.store_err}, 32'd0);
    chk("rst_ram_re", {31'd0, bus.ram_re}, 32'd0);
    chk("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
    chk("rst_ram_be", {28'd0, bus.ram_be}, 32'd0);
    chk("rst_ram_addr", {22'd0, bus.ram_addr}, 32'd0);
    chk("rst_ram_di", bus.ram_di, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    tick();

    issue(1'b1, 12'h010, 2'd2, 1'b0, 32'hDEADBEEF, 1'b1, "st_word");
    @(negedge CLK);
`ifndef STORE_ACK_EN
    chk("st_word_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
`endif
    chk("st_word_store_err", {31'd0, bus.store_err}, 32'd0);
    tick();

    issue(1'b0, 12'h012, 2'd1, 1'b0, 32'd0, 1'b1, "ld_half");
    @(negedge CLK);
    chk("ld_half_latency", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ld_half_data", bus.rsp_data, 32'h0000DEAD);
    tick();

    issue(1'b1, 12'h013, 2'd0, 1'b0, 32'h00000080, 1'b1, "st_byte");
    issue(1'b0, 12'h013, 2'd0, 1'b1, 32'd0, 1'b1, "ld_byte_s");
    issue(1'b0, 12'h013, 2'd0, 1'b0, 32'd0, 1'b1, "ld_byte_u");
    issue(1'b0, 12'h012, 2'd1, 1'b1, 32'd0, 1'b1, "ld_half_s");
    issue(1'b0, 12'h010, 2'd2, 1'b0, 32'd0, 1'b1, "ld_word");
    issue(1'b1, 12'h016, 2'd1, 1'b0, 32'h00001234, 1'b1, "st_half");
    issue(1'b0, 12'h014, 2'd2, 1'b0, 32'd0, 1'b1, "ld_word2");
    tick();

    issue(1'b0, 12'h011, 2'd1, 1'b0, 32'd0, 1'b1, "ld_mis");
    @(negedge CLK);
    chk("ld_mis_latency", {31'd0, bus.rsp_valid}, 32'd1);
    chk("ld_mis_rsp_err", {31'd0, bus.rsp_err}, 32'd1);
    tick();
    issue(1'b0, 12'h010, 2'd3, 1'b0, 32'd0, 1'b1, "ld_ill");
    issue(1'b1, 12'h002, 2'd2, 1'b0, 32'h12345678, 1'b1, "st_mis");
    @(negedge CLK);
    chk("st_mis_pulse", {31'd0, bus.store_err}, 32'd1);
    tick();
    @(negedge CLK);
    chk("st_mis_pulse_end", {31'd0, bus.store_err}, 32'd0);
    tick();
    issue(1'b0, 12'h000, 2'd2, 1'b0, 32'd0, 1'b1, "ld_after_st_mis");
    tick();

    bus.rsp_ready = 1'b0;
    issue(1'b0, 12'h010, 2'd2, 1'b0, 32'd0, 1'b1, "bp_ld1");
    issue(1'b0, 12'h012, 2'd1, 1'b0, 32'd0, 1'b1, "bp_ld2");
    issue(1'b0, 12'h012, 2'd1, 1'b1, 32'd0, 1'b0, "bp_ld3_blocked");
    @(negedge CLK);
    chk("bp_head_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_head_data", bus.rsp_data, 32'h80ADBEEF);
`ifndef STORE_ACK_EN
    bus.req_write = 1'b1;
    #1;
    chk("bp_store_ready", {31'd0, bus.req_ready}, 32'd1);
    bus.req_write = 1'b0;
`endif
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    issue(1'b0, 12'h012, 2'd1, 1'b1, 32'd0, 1'b1, "bp_ld3");
    tick();
    tick();
    chk("bp_drained", q.size(), 32'd0);

    bus.rsp_ready = 1'b0;
    issue(1'b0, 12'h010, 2'd2, 1'b0, 32'd0, 1'b1, "rst_ld_a");
    issue(1'b0, 12'h013, 2'd0, 1'b1, 32'd0, 1'b1, "rst_ld_b");
    RESET = 1'b1;
    @(negedge CLK);
    chk("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, bus.req_ready}, 32'd0);
    tick();
    RESET = 1'b0;
    q.delete();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("rst_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_after_ready", {31'd0, bus.req_ready}, 32'd1);
      tick();
    end

    issue(1'b0, 12'h013, 2'd0, 1'b0, 32'd0, 1'b1, "post_rst_ld");
    @(negedge CLK);
    chk("post_rst_latency", {31'd0, bus.rsp_valid}, 32'd1);
    tick();
    tick();
    chk("final_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
